ffs_decode_m: RTL
=================

// Module: ffs_decode_m
// PURPOSE
//  Inverse of the find-first-set encoder: collects a stream of bit indices and
//  decodes each one to a one-hot bit, ORing it into a mask register. The index
//  with idx_last closes the frame, and the assembled mask is presented on a
//  valid/ready output.
//  Used to rebuild request/grant bitmaps from index streams produced by ffs_m.
// PARAMETERS
//  MASK_WIDTH  8  width of the rebuilt mask; >=1
//  SIDE        0  0: idx counts from bit 0 (LSB); 1: idx counts from bit MASK_WIDTH-1
//  IDX_WIDTH   $clog2(max(MASK_WIDTH,2))  derived; do not override
//  CNT_WIDTH   $clog2(MASK_WIDTH+1)       derived; do not override
// PORTS
//  clk         in   1          single clock, rising edge
//  rst         in   1          asynchronous, active-high reset
//  idx_valid   in   1          idx/idx_last valid
//  idx_ready   out  1          block accepts an index this cycle
//  idx         in   IDX_WIDTH  bit index to set
//  idx_last    in   1          this index closes the frame
//  mask_valid  out  1          mask/mask_count/err/dup valid
//  mask_ready  in   1          consumer takes the mask
//  mask        out  MASK_WIDTH assembled mask
//  mask_count  out  CNT_WIDTH  number of distinct bits set (popcount of mask)
//  err         out  1          frame contained idx >= MASK_WIDTH
//  dup         out  1          frame set an already-set bit (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async): state=ACCUM; mask, mask_count, err, dup = 0; mask_valid = 0;
//    idx_ready = 1 (combinational from state). Reset mid-frame discards partial mask.
//  - Accept = idx_valid & idx_ready. idx_ready = (state==ACCUM).
//  - Bit position: pos = SIDE ? MASK_WIDTH-1-idx : idx.
//  - ACCUM, accept, idx<MASK_WIDTH: mask[pos] <= 1. If the bit was clear,
//    mask_count++. mask_count never exceeds MASK_WIDTH.
//  - ACCUM, accept, idx>=MASK_WIDTH (non-power-of-2 widths only): mask is
//    unchanged; err <= 1 (sticky for the frame).
//  - ACCUM, accept with idx_last=1: same update, then state <= HOLD.
//    mask_valid = 1 on the next cycle, so latency is 1 clk from last accept.
//  - A frame may contain a single index (idx_last on the first beat).
//    Empty frames do not exist.
//  - HOLD: mask_valid=1; mask, mask_count, err and dup are stable; idx_ready=0.
//    On mask_ready: mask, count, err and dup are cleared, state <= ACCUM.
//    idx_ready is 1 the cycle after the handshake; no same-cycle overlap.
//  - mask_valid is never withdrawn before mask_ready. mask_ready is ignored in ACCUM.
//  - idx, idx_last, idx_valid are don't-care when not accepted. idx may be X when
//    idx_valid=0 and must not corrupt state.
//  - All outputs come from registers except idx_ready, which is decoded from state.
// CONFIGURATION
//  FFS_DECODE_DUP_CHECK_EN
//  - defined: dup <= 1 (sticky per frame) when an accepted in-range idx targets
//    a bit already set in the current frame. mask and mask_count are unaffected.
//  - undefined: dup tied 0; no duplicate-compare logic.
// TESTING
//  1 W=8,SIDE=0: idx 3,0,7(last) -> 1 clk later mask=8'h89,count=3,err=0,dup=0
//  2 W=8,SIDE=1: idx 0(last) -> mask=8'h80,count=1; single-beat frame closes
//  3 W=5: idx 2,6(last) -> mask=5'b00100,count=1,err=1; next frame err=0
//  4 DUP_EN: idx 4,4(last) -> mask=8'h10,count=1,dup=1; without macro dup=0
//  5 HOLD with mask_ready=0 for 10 clk while idx_valid=1 -> idx_ready=0,
//    mask stable; mask_ready=1 -> idx_ready=1 next clk, mask=0
//  6 rst pulse after idx 1,2 (no last) -> all outputs 0; then idx 5(last)
//    -> mask=8'h20 only

Source files
------------

// File: rtl/ffs_decode_m.sv
// Rebuilds a one-hot mask from a stream of bit indices; the frame closes on idx_last and is held until mask_ready.
// Latency 1 clk from last accept; idx_ready low while holding. Optional duplicate flag: FFS_DECODE_DUP_CHECK_EN.
module ffs_decode_m #(
  parameter int MASK_WIDTH = 8,
  parameter int SIDE       = 0,
  parameter int IDX_WIDTH  = $clog2((MASK_WIDTH > 2) ? MASK_WIDTH : 2),
  parameter int CNT_WIDTH  = $clog2(MASK_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  idx_valid,
  output logic                  idx_ready,
  input  logic [IDX_WIDTH-1:0]  idx,
  input  logic                  idx_last,
  output logic                  mask_valid,
  input  logic                  mask_ready,
  output logic [MASK_WIDTH-1:0] mask,
  output logic [CNT_WIDTH-1:0]  mask_count,
  output logic                  err,
  output logic                  dup
);

  typedef enum logic {ST_ACCUM, ST_HOLD} state_t;

  state_t                state_q;
  logic [MASK_WIDTH-1:0] mask_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  err_q;
  logic [MASK_WIDTH-1:0] hit;
  logic                  in_range;
  logic                  new_bit;

  // An out-of-range index matches no position, so an empty hit vector flags it.
  always_comb begin
    hit = '0;
    for (int i = 0; i < MASK_WIDTH; i++) begin
      if (idx == IDX_WIDTH'((SIDE != 0) ? (MASK_WIDTH - 1 - i) : i)) hit[i] = 1'b1;
    end
  end

  assign in_range = |hit;
  assign new_bit  = |(hit & ~mask_q);

`ifdef FFS_DECODE_DUP_CHECK_EN
  logic dup_q;
  logic dup_hit;
  assign dup_hit = |(hit & mask_q);
  assign dup     = dup_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dup_q <= 1'b0;
    end else if (state_q == ST_ACCUM) begin
      if (idx_valid && dup_hit) dup_q <= 1'b1;
    end else if (mask_ready) begin
      dup_q <= 1'b0;
    end
  end
`else
  assign dup = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      mask_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (idx_valid) begin
            mask_q <= mask_q | hit;
            if (new_bit)   cnt_q <= cnt_q + CNT_WIDTH'(1);
            if (!in_range) err_q <= 1'b1;
            if (idx_last)  state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (mask_ready) begin
            mask_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            state_q <= ST_ACCUM;
          end
        end
        default: state_q <= ST_ACCUM;
      endcase
    end
  end

  assign idx_ready  = (state_q == ST_ACCUM);
  assign mask_valid = (state_q == ST_HOLD);
  assign mask       = mask_q;
  assign mask_count = cnt_q;
  assign err        = err_q;

endmodule
